serial_frame_rx: RTL

Receiving end of the team's self-framed bit-serial link. It recovers parallel words from a single serial line with no side-band enable or busy strobe, using start, parity and stop bits for framing. It sits at the far end of the framed serializer on the same clock domain, one bit per i_clk. It delivers words through a one-entry valid/ready output register and reports framing, parity and overrun errors.

---
 rtl/serdes_pkg.sv | 7 +
 rtl/serial_frame_rx_if.sv | 16 +
 rtl/serial_frame_rx.sv | 89 ++++++++
 3 files changed

// File: rtl/serdes_pkg.sv
// serdes_pkg: shared state encoding and frame helpers for the framed serial link.
package serdes_pkg;
  typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} rx_state_t;
  function automatic int frame_bits(input int width, input bit parity_en);
    return width + 2 + int'(parity_en);
  endfunction
endpackage

// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial line in, word handshake and status out.
interface serial_frame_rx_if #(parameter int WIDTH = 8);
  logic             i_data;
  logic             i_ready;
  logic             i_clr;
  logic [WIDTH-1:0] o_data;
  logic             o_valid;
  logic             o_perr;
  logic             o_frame_err;
  logic             o_overrun;
  logic             o_busy;
  modport master (input i_data, i_ready, i_clr,
                  output o_data, o_valid, o_perr, o_frame_err, o_overrun, o_busy);
  modport slave  (output i_data, i_ready, i_clr,
                  input o_data, o_valid, o_perr, o_frame_err, o_overrun, o_busy);
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: deframes start/data/parity/stop bits into a one-entry valid/ready word buffer.
module serial_frame_rx
  import serdes_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit PARITY_EN = 1'b1,
  parameter bit IDLE_LVL  = 1'b1
) (
  input logic             i_clk,
  input logic             i_rst_n,
  serial_frame_rx_if.master bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  rx_state_t        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] shift_q, shift_d, data_q, data_d;
  logic             par_q, par_d, valid_q, valid_d, perr_q, perr_d;
  logic             ferr_q, ferr_d, ovr_q, ovr_d, good, load, blocked;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    good    = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: if (bus.i_data != IDLE_LVL) begin
        state_d = DATA;
        cnt_d   = '0;
      end
      DATA: begin
        shift_d = {shift_q[WIDTH-2:0], bus.i_data};
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = PARITY_EN ? PARITY : STOP;
        end
      end
      PARITY: begin
        par_d   = bus.i_data;
        state_d = STOP;
      end
      STOP: begin
        good    = bus.i_data == IDLE_LVL;
        ferr_d  = !good;
        state_d = good ? IDLE : BREAK;
      end
      BREAK: state_d = (bus.i_data == IDLE_LVL) ? IDLE : BREAK;
      default: state_d = IDLE;
    endcase
    // A full buffer that is not being drained this edge drops the new word.
    blocked = valid_q & ~bus.i_ready;
    load    = good & ~blocked;
    valid_d = load | blocked;
    data_d  = load ? shift_q : data_q;
    perr_d  = load ? (PARITY_EN ? (^shift_q ^ par_q) : 1'b0) : perr_q;
    ovr_d   = (good & blocked) | (ovr_q & ~bus.i_clr);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end
  assign bus.o_data      = data_q;
  assign bus.o_valid     = valid_q;
  assign bus.o_perr      = perr_q;
  assign bus.o_frame_err = ferr_q;
  assign bus.o_overrun   = ovr_q;
  assign bus.o_busy      = state_q != IDLE;
endmodule
